// File: rtl/caxi4interconnect_revision_slave_if.sv
// AXI4-Lite control-port bundle for the revision read-back slave.
// The slave modport is the register end; the master modport is the host end.
interface caxi4interconnect_revision_slave_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] S_ARADDR;
    logic                  S_ARVALID;
    logic                  S_ARREADY;
    logic [31:0]           S_RDATA;
    logic [1:0]            S_RRESP;
    logic                  S_RVALID;
    logic                  S_RREADY;
    logic [ADDR_WIDTH-1:0] S_AWADDR;
    logic                  S_AWVALID;
    logic                  S_AWREADY;
    logic [31:0]           S_WDATA;
    logic [3:0]            S_WSTRB;
    logic                  S_WVALID;
    logic                  S_WREADY;
    logic [1:0]            S_BRESP;
    logic                  S_BVALID;
    logic                  S_BREADY;

    modport slave (
        input  S_ARADDR, S_ARVALID, S_RREADY,
        input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
        output S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
        output S_AWREADY, S_WREADY, S_BRESP, S_BVALID
    );

    modport master (
        output S_ARADDR, S_ARVALID, S_RREADY,
        output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
        input  S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
        input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID
    );
endinterface

// File: rtl/caxi4interconnect_revision_slave.sv
// AXI4-Lite slave returning the core revision word, its byte fields and a
// saturating count of successful reads that the host clears with a write.
module caxi4interconnect_revision_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] devRevision,
    caxi4interconnect_revision_slave_if.slave s_axi
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {R_IDLE, R_RESP} rState_t;
    typedef enum logic {W_IDLE, W_RESP} wState_t;

    rState_t               r_rState;
    rState_t               w_rStateNext;
    logic                  r_arReady;
    logic                  w_arReadyNext;
    logic [31:0]           r_rData;
    logic [31:0]           w_rDataNext;
    logic [1:0]            r_rResp;
    logic [1:0]            w_rRespNext;

    wState_t               r_wState;
    wState_t               w_wStateNext;
    logic                  r_awReady;
    logic                  w_awReadyNext;
    logic                  r_wReady;
    logic                  w_wReadyNext;
    logic                  r_awGot;
    logic                  w_awGotNext;
    logic                  r_wGot;
    logic                  w_wGotNext;
    logic [ADDR_WIDTH-1:0] r_awAddr;
    logic [ADDR_WIDTH-1:0] w_awAddrNext;
    logic [3:0]            r_wStrb;
    logic [3:0]            w_wStrbNext;
    logic [1:0]            r_bResp;
    logic [1:0]            w_bRespNext;

    logic [CNT_WIDTH-1:0]  r_count;
    logic [31:0]           w_decData;
    logic [1:0]            w_decResp;
    logic                  w_rOkHandshake;
    logic                  w_awHandshake;
    logic                  w_wHandshake;
    logic [ADDR_WIDTH-1:0] w_awAddrEff;
    logic [3:0]            w_wStrbEff;
    logic                  w_writeOk;
    logic                  w_countClear;
    logic                  w_unusedWdata;

    assign w_unusedWdata = ^s_axi.S_WDATA;

    // Unaligned offsets take priority over the unmapped check.
    always_comb begin
        w_decData = 32'h0;
        w_decResp = RESP_OKAY;
        if (s_axi.S_ARADDR[1:0] != 2'b00) begin
            w_decResp = RESP_SLVERR;
        end else if (|s_axi.S_ARADDR[ADDR_WIDTH-1:5]) begin
            w_decResp = RESP_DECERR;
        end else begin
            case (s_axi.S_ARADDR[4:2])
                3'd0:    w_decData = devRevision;
                3'd1:    w_decData = {24'h0, devRevision[31:24]};
                3'd2:    w_decData = {24'h0, devRevision[23:16]};
                3'd3:    w_decData = {24'h0, devRevision[15:8]};
                3'd4:    w_decData = {24'h0, devRevision[7:0]};
                3'd5:    w_decData = 32'(r_count);
                default: w_decResp = RESP_DECERR;
            endcase
        end
    end

    always_comb begin
        w_rStateNext  = r_rState;
        w_arReadyNext = r_arReady;
        w_rDataNext   = r_rData;
        w_rRespNext   = r_rResp;
        case (r_rState)
            R_IDLE: begin
                w_arReadyNext = 1'b1;
                if (s_axi.S_ARVALID && r_arReady) begin
                    w_rStateNext  = R_RESP;
                    w_arReadyNext = 1'b0;
                    w_rDataNext   = w_decData;
                    w_rRespNext   = w_decResp;
                end
            end
            R_RESP: begin
                w_arReadyNext = 1'b0;
                if (s_axi.S_RREADY) begin
                    w_rStateNext  = R_IDLE;
                    w_arReadyNext = 1'b1;
                end
            end
            default: begin
                w_rStateNext  = R_IDLE;
                w_arReadyNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rState  <= R_IDLE;
            r_arReady <= 1'b0;
            r_rData   <= 32'h0;
            r_rResp   <= RESP_OKAY;
        end else begin
            r_rState  <= w_rStateNext;
            r_arReady <= w_arReadyNext;
            r_rData   <= w_rDataNext;
            r_rResp   <= w_rRespNext;
        end
    end

    assign w_rOkHandshake = (r_rState == R_RESP) && s_axi.S_RREADY && (r_rResp == RESP_OKAY);

    assign w_awHandshake = s_axi.S_AWVALID && r_awReady;
    assign w_wHandshake  = s_axi.S_WVALID && r_wReady;
    assign w_awAddrEff   = w_awHandshake ? s_axi.S_AWADDR : r_awAddr;
    assign w_wStrbEff    = w_wHandshake ? s_axi.S_WSTRB : r_wStrb;
    assign w_writeOk     = (w_awAddrEff == ADDR_WIDTH'(8'h14)) && (w_wStrbEff != 4'h0);

    // AW and W are latched independently; the response starts once both are in.
    always_comb begin
        w_wStateNext  = r_wState;
        w_awReadyNext = r_awReady;
        w_wReadyNext  = r_wReady;
        w_awGotNext   = r_awGot;
        w_wGotNext    = r_wGot;
        w_awAddrNext  = r_awAddr;
        w_wStrbNext   = r_wStrb;
        w_bRespNext   = r_bResp;
        w_countClear  = 1'b0;
        case (r_wState)
            W_IDLE: begin
                w_awGotNext   = r_awGot | w_awHandshake;
                w_wGotNext    = r_wGot | w_wHandshake;
                w_awAddrNext  = w_awAddrEff;
                w_wStrbNext   = w_wStrbEff;
                w_awReadyNext = !w_awGotNext;
                w_wReadyNext  = !w_wGotNext;
                if (w_awGotNext && w_wGotNext) begin
                    w_wStateNext = W_RESP;
                    w_awGotNext  = 1'b0;
                    w_wGotNext   = 1'b0;
                    w_bRespNext  = w_writeOk ? RESP_OKAY : RESP_SLVERR;
                    w_countClear = w_writeOk;
                end
            end
            W_RESP: begin
                w_awReadyNext = 1'b0;
                w_wReadyNext  = 1'b0;
                if (s_axi.S_BREADY) begin
                    w_wStateNext  = W_IDLE;
                    w_awReadyNext = 1'b1;
                    w_wReadyNext  = 1'b1;
                end
            end
            default: begin
                w_wStateNext  = W_IDLE;
                w_awReadyNext = 1'b0;
                w_wReadyNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wState  <= W_IDLE;
            r_awReady <= 1'b0;
            r_wReady  <= 1'b0;
            r_awGot   <= 1'b0;
            r_wGot    <= 1'b0;
            r_awAddr  <= '0;
            r_wStrb   <= 4'h0;
            r_bResp   <= RESP_OKAY;
        end else begin
            r_wState  <= w_wStateNext;
            r_awReady <= w_awReadyNext;
            r_wReady  <= w_wReadyNext;
            r_awGot   <= w_awGotNext;
            r_wGot    <= w_wGotNext;
            r_awAddr  <= w_awAddrNext;
            r_wStrb   <= w_wStrbNext;
            r_bResp   <= w_bRespNext;
        end
    end

    // A clear landing on the same edge as a read increment wins.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_count <= '0;
        end else if (w_countClear) begin
            r_count <= '0;
        end else if (w_rOkHandshake && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign s_axi.S_ARREADY = r_arReady;
    assign s_axi.S_RVALID  = (r_rState == R_RESP);
    assign s_axi.S_RDATA   = r_rData;
    assign s_axi.S_RRESP   = r_rResp;
    assign s_axi.S_AWREADY = r_awReady;
    assign s_axi.S_WREADY  = r_wReady;
    assign s_axi.S_BVALID  = (r_wState == W_RESP);
    assign s_axi.S_BRESP   = r_bResp;

endmodule

// File: tb/tb_caxi4interconnect_revision_slave.sv
// Directed bench for the revision slave; a second instance with a 2-bit
// counter shares the same stimulus to exercise saturation.
module tb_caxi4interconnect_revision_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] devRevision;
    int          testsRun = 0;
    int          testsFailed = 0;

    caxi4interconnect_revision_slave_if #(.ADDR_WIDTH(12)) bus();
    caxi4interconnect_revision_slave_if #(.ADDR_WIDTH(12)) bus2();

    assign bus2.S_ARADDR  = bus.S_ARADDR;
    assign bus2.S_ARVALID = bus.S_ARVALID;
    assign bus2.S_RREADY  = bus.S_RREADY;
    assign bus2.S_AWADDR  = bus.S_AWADDR;
    assign bus2.S_AWVALID = bus.S_AWVALID;
    assign bus2.S_WDATA   = bus.S_WDATA;
    assign bus2.S_WSTRB   = bus.S_WSTRB;
    assign bus2.S_WVALID  = bus.S_WVALID;
    assign bus2.S_BREADY  = bus.S_BREADY;

    caxi4interconnect_revision_slave #(.ADDR_WIDTH(12), .CNT_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .devRevision(devRevision), .s_axi(bus)
    );

    caxi4interconnect_revision_slave #(.ADDR_WIDTH(12), .CNT_WIDTH(2)) dut2 (
        .ACLK(ACLK), .ARESET(ARESET), .devRevision(devRevision), .s_axi(bus2)
    );

    always #5 ACLK = ~ACLK;

    logic [11:0] fieldAddr [5] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010};
    logic [31:0] fieldData [5] = '{32'h15062901, 32'h15, 32'h06, 32'h29, 32'h01};
    logic [11:0] errAddr   [3] = '{12'h002, 12'h018, 12'h114};
    logic [1:0]  errResp   [3] = '{2'b10, 2'b11, 2'b11};

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic doRead(input logic [11:0] addr, input int stall, input bit changeRev,
                          output logic [31:0] d1, output logic [1:0] r1,
                          output logic [31:0] d2, output bit latOk, output bit stableOk);
        int n = 0;
        logic pre;
        logic [31:0] d0;
        logic [1:0] r0;
        d1 = 32'h0; r1 = 2'b01; d2 = 32'h0; latOk = 1'b0; stableOk = 1'b0;
        bus.S_ARADDR  = addr;
        bus.S_ARVALID = 1'b1;
        bus.S_RREADY  = 1'b0;
        while (bus.S_ARREADY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.S_ARREADY !== 1'b1) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL read_arready_timeout: got %b expected 1", bus.S_ARREADY);
            bus.S_ARVALID = 1'b0;
            return;
        end
        pre = bus.S_RVALID;
        tick();
        bus.S_ARVALID = 1'b0;
        latOk = (pre === 1'b0) && (bus.S_RVALID === 1'b1);
        if (changeRev) devRevision = ~devRevision;
        d0 = bus.S_RDATA;
        r0 = bus.S_RRESP;
        stableOk = 1'b1;
        repeat (stall) begin
            tick();
            if (bus.S_RVALID !== 1'b1 || bus.S_RDATA !== d0 || bus.S_RRESP !== r0 || bus.S_ARREADY !== 1'b0)
                stableOk = 1'b0;
        end
        d1 = bus.S_RDATA;
        r1 = bus.S_RRESP;
        d2 = bus2.S_RDATA;
        bus.S_RREADY = 1'b1;
        tick();
        bus.S_RREADY = 1'b0;
        if (changeRev) devRevision = ~devRevision;
    endtask

    task automatic doWrite(input logic [11:0] addr, input logic [3:0] strb,
                           input int wDelay, input int awDelay,
                           output logic [1:0] bresp, output bit onTime, output bit readyOk);
        bit awDone = 1'b0;
        bit wDone = 1'b0;
        bit awHs, wHs;
        int t = 0;
        bresp = 2'b01; onTime = 1'b0; readyOk = 1'b1;
        while (!(awDone && wDone) && t < 20) begin
            bus.S_AWADDR  = addr;
            bus.S_WSTRB   = strb;
            bus.S_WDATA   = $urandom;
            bus.S_AWVALID = !awDone && (t >= awDelay);
            bus.S_WVALID  = !wDone && (t >= wDelay);
            awHs = bus.S_AWVALID && (bus.S_AWREADY === 1'b1);
            wHs  = bus.S_WVALID && (bus.S_WREADY === 1'b1);
            tick();
            if (awHs) awDone = 1'b1;
            if (wHs) wDone = 1'b1;
            if (!(awDone && wDone)) begin
                if (bus.S_AWREADY !== !awDone || bus.S_WREADY !== !wDone || bus.S_BVALID !== 1'b0)
                    readyOk = 1'b0;
            end
            t++;
        end
        bus.S_AWVALID = 1'b0;
        bus.S_WVALID  = 1'b0;
        if (!(awDone && wDone)) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL write_handshake_timeout: got aw=%b w=%b expected both done", awDone, wDone);
            return;
        end
        onTime = (bus.S_BVALID === 1'b1);
        bresp = bus.S_BRESP;
        bus.S_BREADY = 1'b1;
        tick();
        bus.S_BREADY = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        testsRun++;
        if ({bus.S_ARREADY, bus.S_RVALID, bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID} !== 5'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                     {bus.S_ARREADY, bus.S_RVALID, bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID});
        end
        testsRun++;
        if ({bus.S_RDATA, bus.S_RRESP, bus.S_BRESP} !== 36'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: got %h expected 0", {bus.S_RDATA, bus.S_RRESP, bus.S_BRESP});
        end
        tick();
        tick();
        testsRun++;
        if (bus.S_ARREADY !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_held_arready: got %b expected 0", bus.S_ARREADY);
        end
        ARESET = 1'b0;
        #1;
        testsRun++;
        if ({bus.S_ARREADY, bus.S_AWREADY, bus.S_WREADY} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_noedge: got %b expected 000",
                     {bus.S_ARREADY, bus.S_AWREADY, bus.S_WREADY});
        end
        tick();
        testsRun++;
        if ({bus.S_ARREADY, bus.S_AWREADY, bus.S_WREADY} !== 3'b111) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_ready: got %b expected 111",
                     {bus.S_ARREADY, bus.S_AWREADY, bus.S_WREADY});
        end
    endtask

    task automatic test_count_and_stall;
        logic [31:0] d1, d2;
        logic [1:0] r1;
        bit lat, stable;
        for (int i = 0; i < 3; i++) begin
            doRead(12'h000, 0, 1'b0, d1, r1, d2, lat, stable);
            testsRun++;
            if (r1 !== 2'b00) begin
                testsFailed++;
                $display("[TB] FAIL count_prep_resp: got %b expected 00", r1);
            end
        end
        doRead(12'h014, 5, 1'b0, d1, r1, d2, lat, stable);
        testsRun++;
        if (d1 !== 32'd3) begin
            testsFailed++;
            $display("[TB] FAIL count_three: got %h expected %h", d1, 32'd3);
        end
        testsRun++;
        if (d2 !== 32'd3) begin
            testsFailed++;
            $display("[TB] FAIL count_three_w2: got %h expected %h", d2, 32'd3);
        end
        testsRun++;
        if (stable !== 1'b1 || lat !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL stall_stable: got stable=%b lat=%b expected 1 1", stable, lat);
        end
    endtask

    task automatic test_revision_fields;
        logic [31:0] d1, d2;
        logic [1:0] r1;
        bit lat, stable;
        for (int i = 0; i < 5; i++) begin
            doRead(fieldAddr[i], 1, (i == 0), d1, r1, d2, lat, stable);
            testsRun++;
            if (d1 !== fieldData[i] || r1 !== 2'b00) begin
                testsFailed++;
                $display("[TB] FAIL field_%0d: got %h/%b expected %h/00", i, d1, r1, fieldData[i]);
            end
            testsRun++;
            if (lat !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL field_latency_%0d: got %b expected 1", i, lat);
            end
        end
    endtask

    task automatic test_error_responses;
        logic [31:0] d1, d2;
        logic [1:0] r1;
        bit lat, stable;
        for (int i = 0; i < 3; i++) begin
            doRead(errAddr[i], 0, 1'b0, d1, r1, d2, lat, stable);
            testsRun++;
            if (r1 !== errResp[i] || d1 !== 32'h0) begin
                testsFailed++;
                $display("[TB] FAIL err_%h: got %h/%b expected 0/%b", errAddr[i], d1, r1, errResp[i]);
            end
        end
        doRead(12'h014, 0, 1'b0, d1, r1, d2, lat, stable);
        testsRun++;
        if (d1 !== 32'd9 || d2 !== 32'd3) begin
            testsFailed++;
            $display("[TB] FAIL err_no_count: got %h/%h expected 9/3", d1, d2);
        end
    endtask

    task automatic test_write_clear;
        logic [31:0] d1, d2;
        logic [1:0] r1, br;
        bit lat, stable, onTime, readyOk;
        doWrite(12'h014, 4'hF, 0, 2, br, onTime, readyOk);
        testsRun++;
        if (br !== 2'b00 || onTime !== 1'b1 || readyOk !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL clear_write: got bresp=%b ontime=%b ready=%b expected 00 1 1", br, onTime, readyOk);
        end
        doRead(12'h014, 0, 1'b0, d1, r1, d2, lat, stable);
        testsRun++;
        if (d1 !== 32'd0 || d2 !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL clear_result: got %h/%h expected 0/0", d1, d2);
        end
        doWrite(12'h000, 4'hF, 0, 0, br, onTime, readyOk);
        testsRun++;
        if (br !== 2'b10 || onTime !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL write_bad_addr: got bresp=%b ontime=%b expected 10 1", br, onTime);
        end
        doRead(12'h014, 0, 1'b0, d1, r1, d2, lat, stable);
        testsRun++;
        if (d1 !== 32'd1 || d2 !== 32'd1) begin
            testsFailed++;
            $display("[TB] FAIL bad_addr_keeps: got %h/%h expected 1/1", d1, d2);
        end
        doWrite(12'h014, 4'h0, 1, 0, br, onTime, readyOk);
        testsRun++;
        if (br !== 2'b10 || readyOk !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL write_no_strb: got bresp=%b ready=%b expected 10 1", br, readyOk);
        end
        doRead(12'h014, 0, 1'b0, d1, r1, d2, lat, stable);
        testsRun++;
        if (d1 !== 32'd2 || d2 !== 32'd2) begin
            testsFailed++;
            $display("[TB] FAIL no_strb_keeps: got %h/%h expected 2/2", d1, d2);
        end
    endtask

    task automatic test_saturation;
        logic [31:0] d1, d2;
        logic [1:0] r1;
        bit lat, stable;
        for (int i = 0; i < 5; i++) doRead(12'h000, 0, 1'b0, d1, r1, d2, lat, stable);
        doRead(12'h014, 0, 1'b0, d1, r1, d2, lat, stable);
        testsRun++;
        if (d2 !== 32'd3) begin
            testsFailed++;
            $display("[TB] FAIL saturate_w2: got %h expected 3", d2);
        end
        testsRun++;
        if (d1 !== 32'd8) begin
            testsFailed++;
            $display("[TB] FAIL count_w16: got %h expected 8", d1);
        end
    endtask

    task automatic test_clear_collision;
        logic [31:0] d1, d2;
        logic [1:0] r1;
        bit lat, stable;
        int n = 0;
        bus.S_ARADDR  = 12'h000;
        bus.S_ARVALID = 1'b1;
        while (bus.S_ARREADY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.S_ARVALID = 1'b0;
        bus.S_RREADY  = 1'b1;
        bus.S_AWADDR  = 12'h014;
        bus.S_WSTRB   = 4'hF;
        bus.S_AWVALID = 1'b1;
        bus.S_WVALID  = 1'b1;
        testsRun++;
        if ({bus.S_RVALID, bus.S_AWREADY, bus.S_WREADY} !== 3'b111) begin
            testsFailed++;
            $display("[TB] FAIL collide_setup: got %b expected 111",
                     {bus.S_RVALID, bus.S_AWREADY, bus.S_WREADY});
        end
        tick();
        bus.S_RREADY  = 1'b0;
        bus.S_AWVALID = 1'b0;
        bus.S_WVALID  = 1'b0;
        testsRun++;
        if ({bus.S_RVALID, bus.S_BVALID, bus.S_BRESP} !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL collide_resp: got %b expected 0100", {bus.S_RVALID, bus.S_BVALID, bus.S_BRESP});
        end
        bus.S_BREADY = 1'b1;
        tick();
        bus.S_BREADY = 1'b0;
        doRead(12'h014, 0, 1'b0, d1, r1, d2, lat, stable);
        testsRun++;
        if (d1 !== 32'd0 || d2 !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL collide_clear_wins: got %h/%h expected 0/0", d1, d2);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d1, d2;
        logic [1:0] r1;
        bit lat, stable;
        bus.S_ARADDR  = 12'h000;
        bus.S_ARVALID = 1'b1;
        bus.S_AWADDR  = 12'h000;
        bus.S_WSTRB   = 4'hF;
        bus.S_AWVALID = 1'b1;
        bus.S_WVALID  = 1'b1;
        tick();
        bus.S_ARVALID = 1'b0;
        bus.S_AWVALID = 1'b0;
        bus.S_WVALID  = 1'b0;
        testsRun++;
        if ({bus.S_RVALID, bus.S_BVALID} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL midrst_setup: got %b expected 11", {bus.S_RVALID, bus.S_BVALID});
        end
        #2;
        ARESET = 1'b1;
        #1;
        testsRun++;
        if ({bus.S_RVALID, bus.S_BVALID, bus.S_ARREADY, bus.S_AWREADY} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL midrst_async_drop: got %b expected 0000",
                     {bus.S_RVALID, bus.S_BVALID, bus.S_ARREADY, bus.S_AWREADY});
        end
        #2;
        ARESET = 1'b0;
        tick();
        testsRun++;
        if ({bus.S_ARREADY, bus.S_AWREADY, bus.S_WREADY} !== 3'b111) begin
            testsFailed++;
            $display("[TB] FAIL midrst_ready: got %b expected 111", {bus.S_ARREADY, bus.S_AWREADY, bus.S_WREADY});
        end
        doRead(12'h014, 0, 1'b0, d1, r1, d2, lat, stable);
        testsRun++;
        if (d1 !== 32'd0 || d2 !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_count: got %h/%h expected 0/0", d1, d2);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ARESET        = 1'b1;
        devRevision   = 32'h15062901;
        bus.S_ARADDR  = '0;
        bus.S_ARVALID = 1'b0;
        bus.S_RREADY  = 1'b0;
        bus.S_AWADDR  = '0;
        bus.S_AWVALID = 1'b0;
        bus.S_WDATA   = 32'h0;
        bus.S_WSTRB   = 4'h0;
        bus.S_WVALID  = 1'b0;
        bus.S_BREADY  = 1'b0;
        test_reset();
        test_count_and_stall();
        test_revision_fields();
        test_error_responses();
        test_write_clear();
        test_saturation();
        test_clear_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/caxi4interconnect_revision_slave.md
Name: caxi4interconnect_revision_slave

Overview:
- AXI4-Lite slave that answers register reads of the core revision word and its byte fields over a host-facing control port.
- Takes the 32-bit devRevision word from the revision block as an input.
- Keeps a saturating count of successful reads, which the host can clear by a write.
- Sits beside the crossbar as the read-back end of the revision word, for software and SmartDebug identification of the core build.

Parameters:
- ADDR_WIDTH, 12, width of S_ARADDR/S_AWADDR; only bits [4:0] decode, upper bits must be zero or the access is unmapped.
- CNT_WIDTH, 16, width of the read counter; the counter is zero-extended to 32 bits on read.

Ports:
- ACLK  in  1  single clock; all logic is on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- devRevision  in  32  {year, month, day, build}; sampled at the AR handshake.
- S_ARADDR  in  ADDR_WIDTH  read address.
- S_ARVALID  in  1  read address valid.
- S_ARREADY  out  1  read address ready.
- S_RDATA  out  32  read data.
- S_RRESP  out  2  read response.
- S_RVALID  out  1  read data valid.
- S_RREADY  in  1  read data ready.
- S_AWADDR  in  ADDR_WIDTH  write address.
- S_AWVALID  in  1  write address valid.
- S_AWREADY  out  1  write address ready.
- S_WDATA  in  32  write data; ignored.
- S_WSTRB  in  4  write strobes.
- S_WVALID  in  1  write data valid.
- S_WREADY  out  1  write data ready.
- S_BRESP  out  2  write response.
- S_BVALID  out  1  write response valid.
- S_BREADY  in  1  write response ready.

Behaviour:
- Register map (byte offsets):
  - 0x00: devRevision.
  - 0x04: {24'h0, year = devRevision[31:24]}.
  - 0x08: {24'h0, month = [23:16]}.
  - 0x0C: {24'h0, day = [15:8]}.
  - 0x10: {24'h0, build = [7:0]}.
  - 0x14: read counter, zero-extended.
- Response codes:
  - Address with [1:0]!=0 returns SLVERR (2'b10) with RDATA 0.
  - Aligned address outside the map, or any upper address bit set, returns DECERR (2'b11) with RDATA 0.
  - All other reads return OKAY (2'b00).
- Reset values, asserted asynchronously: ARREADY=0, RVALID=0, RDATA=0, RRESP=0, AWREADY=0, WREADY=0, BVALID=0, BRESP=0, counter=0, both FSMs in IDLE.
- Leaving reset: ARREADY, AWREADY and WREADY rise on the first clock edge after ARESET deasserts.
- Read FSM, two states:
  - R_IDLE: ARREADY=1. On ARVALID, capture decoded data and response into the RDATA/RRESP registers, then go to R_RESP. RVALID rises the next cycle, so latency is 1 cycle.
  - R_RESP: ARREADY=0, RVALID=1. RDATA and RRESP hold stable until RREADY. On RVALID&RREADY return to R_IDLE. Back-to-back reads therefore take 2 cycles each.
- Read counter:
  - Increments by 1 on each R handshake whose RRESP is OKAY.
  - Saturates at all-ones and does not wrap.
  - A read of 0x14 returns the value captured at AR time, i.e. before that read's own increment.
- Write FSM:
  - W_IDLE: AWREADY=1 until AW is captured and WREADY=1 until W is captured. Each ready drops the cycle after its handshake. AW and W may arrive in the same cycle or in either order.
  - Once both are captured, go to W_RESP with BVALID=1 the next cycle.
  - W_RESP: BRESP=OKAY only for aligned address 0x14 with WSTRB!=0; otherwise SLVERR. In the OKAY case the counter clears to 0 on the cycle BVALID rises.
  - On BVALID&BREADY return to W_IDLE and re-assert both readies.
- Simultaneous events:
  - Counter clear and an R-handshake increment in the same cycle: clear wins, result is 0.
  - The read and write FSMs are independent and may be active in the same cycle.
- Reset mid-transaction: any outstanding RVALID/BVALID drops immediately, the response is lost, and the counter returns to 0.
- devRevision is not registered beyond the RDATA capture, so changes after the AR handshake do not affect the response already in flight.

Test Plan:
- devRevision=32'h15062901; read 0x00, 0x04, 0x08, 0x0C, 0x10 -> RDATA 32'h15062901, 32'h15, 32'h06, 32'h29, 32'h01, all RRESP=00, RVALID exactly 1 cycle after each AR handshake.
- Read 0x02 -> RRESP=10, RDATA=0. Read 0x18 -> RRESP=11, RDATA=0. Read 0x014 with ADDR bit 8 set -> RRESP=11. None of these advance the counter: a following read of 0x14 returns the prior OKAY count.
- Three OKAY reads after reset, then read 0x14 -> RDATA=3. Hold RREADY low 5 cycles during that read -> RVALID, RDATA and RRESP stay stable and ARREADY stays low.
- W before AW by 2 cycles, address 0x14, WSTRB=4'hF -> BRESP=00 and counter=0 on the next read. Write 0x00 -> BRESP=10, counter unchanged.
- CNT_WIDTH=2: five OKAY reads of 0x00, then read 0x14 -> RDATA=3 (saturated). Clear write issued in the same cycle as an R handshake -> a subsequent read of 0x14 returns 0.
- Assert ARESET while RVALID=1 and BVALID=1 -> both drop in the same cycle with no clock edge needed. After deassert, ARREADY/AWREADY/WREADY rise on the next edge and read of 0x14 returns 0.
